isa_dma_engine: RTL

ISA DMA slave-cycle handler for the FDC (channel 2) and WD HDD (channel 3, XT mode). It sits beside the ISA I/O bridge on the same ISA pins and AXI4-Lite fabric. The block requests DMA service from the motherboard 8237 and serves DACK-qualified ISA strobes by moving single bytes to or from the peripheral data register over AXI4-Lite. It inserts IOCHRDY wait states, samples terminal count and reports TC and timeout events to the peripherals.

---
 rtl/isa_dma_engine_if.sv | 31 +++
 rtl/isa_dma_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/isa_dma_engine_if.sv
// AXI4-Lite master/slave bundle used by the ISA DMA engine to reach the
// peripheral data registers.
interface isa_dma_engine_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/isa_dma_engine.sv
// ISA DMA slave-cycle handler: serves 8237 DACK cycles for the FDC (ch2) and
// WD HDD (ch3) by moving single bytes over AXI4-Lite, with IOCHRDY wait states.
module isa_dma_engine #(
  parameter logic [31:0] FDC_DATA_ADDR  = 32'h80006014,
  parameter logic [31:0] WD_DATA_ADDR   = 32'h80007100,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] isa_data_in,
  output logic [7:0] isa_data_out,
  output logic       isa_data_oe,
  input  logic       isa_ior_n,
  input  logic       isa_iow_n,
  input  logic       isa_aen,
  input  logic       isa_tc,
  input  logic       isa_dack2_n,
  input  logic       isa_dack3_n,
  output logic       isa_drq2,
  output logic       isa_drq3,
  output logic       isa_iochrdy,
  input  logic       fdc_drq,
  input  logic       wd_drq,
  input  logic       fdc_enable,
  input  logic       wd_enable,
  input  logic       wd_dma_enable,
  isa_dma_engine_if.master m_axi,
  output logic       fdc_tc,
  output logic       wd_tc,
  output logic       dma_error,
  input  logic       error_clear
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, HOLD} state_t;

  state_t      state;
  logic        ior_q, iow_q;
  logic        is_write, ch_lat, tc_lat, timed_out;
  logic [15:0] tmo_cnt;
  logic        err_set;

  logic q2, q3, single, both_dack, ior_fall, iow_fall, strobe_edge;
  logic ch2_busy, ch3_busy, aw_done, w_done, tmo_hit;
  logic unused_rdata;

  assign q2          = !isa_dack2_n && isa_aen && fdc_enable;
  assign q3          = !isa_dack3_n && isa_aen && wd_enable && wd_dma_enable;
  assign single      = q2 ^ q3;
  assign both_dack   = !isa_dack2_n && !isa_dack3_n;
  assign ior_fall    = ior_q && !isa_ior_n;
  assign iow_fall    = iow_q && !isa_iow_n;
  assign strobe_edge = ior_fall || iow_fall;
  assign ch2_busy    = (state != IDLE) && !ch_lat;
  assign ch3_busy    = (state != IDLE) && ch_lat;
  assign aw_done     = !m_axi.awvalid || m_axi.awready;
  assign w_done      = !m_axi.wvalid || m_axi.wready;
  assign tmo_hit     = (state inside {ADDR, DATA, RESP}) && !timed_out &&
                       (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
  assign unused_rdata = &{1'b0, m_axi.rdata[31:8]};

  always_comb begin
    err_set = 1'b0;
    if (state == IDLE && strobe_edge && both_dack)
      err_set = 1'b1;
    if (tmo_hit)
      err_set = 1'b1;
    if (state == DATA && m_axi.rvalid && m_axi.rresp != 2'b00)
      err_set = 1'b1;
    if (state == RESP && m_axi.bvalid && m_axi.bresp != 2'b00)
      err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ior_q         <= 1'b1;
      iow_q         <= 1'b1;
      is_write      <= 1'b0;
      ch_lat        <= 1'b0;
      tc_lat        <= 1'b0;
      timed_out     <= 1'b0;
      tmo_cnt       <= 16'd0;
      isa_data_out  <= 8'hFF;
      isa_data_oe   <= 1'b0;
      isa_drq2      <= 1'b0;
      isa_drq3      <= 1'b0;
      isa_iochrdy   <= 1'b1;
      fdc_tc        <= 1'b0;
      wd_tc         <= 1'b0;
      dma_error     <= 1'b0;
      m_axi.awaddr  <= 32'h0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= 32'h0;
      m_axi.wstrb   <= 4'b0000;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= 32'h0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      ior_q       <= isa_ior_n;
      iow_q       <= isa_iow_n;
      fdc_tc      <= 1'b0;
      wd_tc       <= 1'b0;
      isa_drq2    <= fdc_drq && fdc_enable && !ch2_busy;
      isa_drq3    <= wd_drq && wd_enable && wd_dma_enable && !ch3_busy;
      isa_data_oe <= single && !isa_ior_n;
      dma_error   <= err_set || (dma_error && !error_clear);

      // The ISA master is released at timeout, but the AXI transaction is
      // still allowed to finish so the fabric never sees a withdrawn valid.
      if ((state inside {ADDR, DATA, RESP}) && !timed_out) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if (tmo_hit) begin
          timed_out   <= 1'b1;
          isa_iochrdy <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          tmo_cnt   <= 16'd0;
          timed_out <= 1'b0;
          if (strobe_edge && !both_dack && single) begin
            ch_lat      <= q3;
            tc_lat      <= isa_tc;
            is_write    <= !ior_fall;
            isa_iochrdy <= 1'b0;
            state       <= ADDR;
            if (ior_fall) begin
              m_axi.araddr  <= q3 ? WD_DATA_ADDR : FDC_DATA_ADDR;
              m_axi.arvalid <= 1'b1;
            end else begin
              m_axi.awaddr  <= q3 ? WD_DATA_ADDR : FDC_DATA_ADDR;
              m_axi.wdata   <= {24'h0, isa_data_in};
              m_axi.wstrb   <= 4'b0001;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (!is_write) begin
            if (m_axi.arready) begin
              m_axi.arvalid <= 1'b0;
              m_axi.rready  <= 1'b1;
              state         <= DATA;
            end
          end else begin
            if (m_axi.awready) m_axi.awvalid <= 1'b0;
            if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
            if (aw_done && w_done) begin
              m_axi.bready <= 1'b1;
              state        <= RESP;
            end
          end
        end
        DATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            // After a timeout the ISA side already took 0xFF; late data is dropped.
            if (!timed_out) isa_data_out <= m_axi.rdata[7:0];
            isa_iochrdy <= 1'b1;
            fdc_tc      <= tc_lat && !ch_lat;
            wd_tc       <= tc_lat && ch_lat;
            state       <= HOLD;
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            isa_iochrdy  <= 1'b1;
            fdc_tc       <= tc_lat && !ch_lat;
            wd_tc        <= tc_lat && ch_lat;
            state        <= HOLD;
          end
        end
        HOLD: begin
          // Level test so a strobe that already rose during a timeout still exits.
          if (is_write ? isa_iow_n : isa_ior_n) begin
            isa_data_out <= 8'hFF;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
